wr_512b_to_bram: RTL and testbench

Row writer for the connected-domain filter: takes one 512-bit image row (512 one-bit pixels) and stores it into the shared BRAM as sixteen sequential 32-bit word writes. It uses the top-level BRAM write controller's trig/done handshake. It is the write-side counterpart of the 512-bit row reader and uses the same row/word address layout, so a row written here reads back bit-identical. A per-word mask allows partial-row updates.

---
 rtl/wr_512b_to_bram.sv | 152 +++++++++++++++
 tb/tb_wr_512b_to_bram.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_512b_to_bram.sv
// wr_512b_to_bram
// Stores one 512-bit image row into the shared BRAM as up to sixteen 32-bit
// word writes over the BRAM controller's trig/done handshake. Word i of the
// row (bits [511-32i : 480-32i]) goes to address {row, i}, so the row reader
// sees the same vector. Words whose mask bit is clear are skipped.

module wr_512b_to_bram (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_trig,
   output logic          o_done,
   output logic          o_busy,
   input  logic [8:0]    i_wr_row_num,
   input  logic [511:0]  i_wr_data_512b,
   input  logic [15:0]   i_wr_word_mask,
   output logic [12:0]   o_wr_to_bram_addr,
   output logic [31:0]   o_wr_to_bram_data,
   output logic          o_wr_to_bram_trig,
   input  logic          i_wr_to_bram_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_REQ   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t         state_r,    state_s;
   logic [8:0]     row_r,      row_s;
   logic [511:0]   data_r,     data_s;
   logic [15:0]    mask_r,     mask_s;
   logic [3:0]     idx_r,      idx_s;
   logic           done_pre_r, done_pre_s;
   logic [12:0]    addr_r,     addr_s;
   logic [31:0]    wdata_r,    wdata_s;
   logic           trig_r,     trig_s;

   // Word idx of the row, counted from the MSB end (word 0 = bits [511:480]).
   function automatic logic [31:0] word_sel(input logic [511:0] row_data,
                                            input logic [3:0]   idx);
      logic [9:0] base;
      base     = 10'd511 - {1'b0, idx, 5'd0};
      word_sel = row_data[base -: 32];
   endfunction

   // Next-state and next-output decode; every register holds unless changed.
   always_comb begin
      state_s    = state_r;
      row_s      = row_r;
      data_s     = data_r;
      mask_s     = mask_r;
      idx_s      = idx_r;
      done_pre_s = done_pre_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      trig_s     = trig_r;
      case (state_r)
         ST_IDLE: begin
            done_pre_s = 1'b0;
            trig_s     = 1'b0;
            if (i_trig) begin
               row_s   = i_wr_row_num;
               data_s  = i_wr_data_512b;
               mask_s  = i_wr_word_mask;
               idx_s   = 4'd0;
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            trig_s = 1'b0;
            if (mask_r[idx_r]) begin
               addr_s  = {row_r, idx_r};
               wdata_s = word_sel(data_r, idx_r);
               trig_s  = 1'b1;
               state_s = ST_REQ;
            end else if (idx_r == 4'd15) begin
               state_s = ST_DONE;
            end else begin
               idx_s   = idx_r + 4'd1;
               state_s = ST_SETUP;
            end
         end
         ST_REQ: begin
            if (i_wr_to_bram_done) begin
               // Dropping trig here guarantees a low cycle before the next word.
               trig_s = 1'b0;
               if (idx_r == 4'd15) begin
                  state_s = ST_DONE;
               end else begin
                  idx_s   = idx_r + 4'd1;
                  state_s = ST_SETUP;
               end
            end else begin
               trig_s  = 1'b1;
               state_s = ST_REQ;
            end
         end
         ST_DONE: begin
            trig_s = 1'b0;
            if (!i_trig) begin
               // Upstream already released (or dropped early): leave without a pulse.
               done_pre_s = 1'b0;
               state_s    = ST_IDLE;
            end else begin
               done_pre_s = 1'b1;
               state_s    = ST_DONE;
            end
         end
         default: begin
            trig_s     = 1'b0;
            done_pre_s = 1'b0;
            state_s    = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything including the bus outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r    <= ST_IDLE;
         row_r      <= 9'd0;
         data_r     <= 512'd0;
         mask_r     <= 16'd0;
         idx_r      <= 4'd0;
         done_pre_r <= 1'b0;
         addr_r     <= 13'd0;
         wdata_r    <= 32'd0;
         trig_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         row_r      <= row_s;
         data_r     <= data_s;
         mask_r     <= mask_s;
         idx_r      <= idx_s;
         done_pre_r <= done_pre_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         trig_r     <= trig_s;
      end
   end

   assign o_wr_to_bram_addr = addr_r;
   assign o_wr_to_bram_data = wdata_r;
   assign o_wr_to_bram_trig = trig_r;
   assign o_busy            = (state_r != ST_IDLE);
   // Qualified with i_trig so that done can never be seen once upstream lets go.
   assign o_done            = done_pre_r & i_trig;

endmodule

// File: tb/tb_wr_512b_to_bram.sv
// Bench for wr_512b_to_bram: a BRAM controller model with programmable done
// latency records every write, checks it against a scoreboard of expected
// writes, and enforces the trig re-arm gap between words.

module tb_wr_512b_to_bram;

   logic          clk = 1'b0;
   logic          rstn;
   logic          trig;
   logic          done;
   logic          busy;
   logic [8:0]    row_num;
   logic [511:0]  wdata;
   logic [15:0]   wmask;
   logic [12:0]   bram_addr;
   logic [31:0]   bram_data;
   logic          bram_trig;
   logic          bram_done = 1'b0;

   typedef struct packed {
      logic [12:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         got_e;
   logic [31:0] mem [0:8191];
   int          total = 0;
   int          bad = 0;
   int          d_lat = 2;
   int          cnt = 0;
   int          writes = 0;
   bit          done_last = 1'b0;

   always #5 clk = ~clk;

   wr_512b_to_bram dut (
      .i_clk             (clk),
      .i_rstn            (rstn),
      .i_trig            (trig),
      .o_done            (done),
      .o_busy            (busy),
      .i_wr_row_num      (row_num),
      .i_wr_data_512b    (wdata),
      .i_wr_word_mask    (wmask),
      .o_wr_to_bram_addr (bram_addr),
      .o_wr_to_bram_data (bram_data),
      .o_wr_to_bram_trig (bram_trig),
      .i_wr_to_bram_done (bram_done)
   );

   // BRAM controller model: done rises d_lat cycles after trig is first seen.
   always @(negedge clk) begin
      if (!rstn) begin
         cnt       = 0;
         bram_done = 1'b0;
         done_last = 1'b0;
      end else begin
         if (done_last) begin
            total++;
            if (bram_trig !== 1'b0) begin
               bad++;
               $display("FAIL trig_gap got=%b want=0 at %0t", bram_trig, $time);
            end
         end
         if (bram_trig === 1'b1) begin
            cnt++;
            if (cnt == d_lat + 1) begin
               bram_done = 1'b1;
               mem[bram_addr] = bram_data;
               writes++;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_write got addr=%h data=%h want none", bram_addr, bram_data);
               end else begin
                  got_e = exp_q.pop_front();
                  if (bram_addr !== got_e.addr || bram_data !== got_e.data) begin
                     bad++;
                     $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                              bram_addr, bram_data, got_e.addr, got_e.data);
                  end
               end
            end else begin
               bram_done = 1'b0;
            end
         end else begin
            cnt       = 0;
            bram_done = 1'b0;
         end
         done_last = bram_done;
      end
   end

   task automatic push_expected(input logic [8:0] row, input logic [511:0] data,
                                input logic [15:0] mask);
      wr_t e;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
            e.addr = {row, i[3:0]};
            e.data = data[511 - 32*i -: 32];
            exp_q.push_back(e);
         end
      end
   endtask

   // Drive a request in the current IDLE cycle; returns just after the acceptance edge.
   task automatic start(input logic [8:0] row, input logic [511:0] data,
                        input logic [15:0] mask);
      @(negedge clk);
      row_num = row;
      wdata   = data;
      wmask   = mask;
      trig    = 1'b1;
      push_expected(row, data, mask);
      @(posedge clk);
   endtask

   task automatic scramble();
      row_num = 9'($urandom);
      wmask   = 16'($urandom);
      for (int i = 0; i < 16; i++) wdata[32*i +: 32] = $urandom;
   endtask

   task automatic rand_row(output logic [511:0] v);
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
   endtask

   task automatic run_to_done(input int exp_lat, input string name);
      int cyc = 0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) scramble();
         if (done === 1'b1) break;
      end
      total++;
      if (cyc !== exp_lat) begin
         bad++;
         $display("FAIL %s_latency got=%0d want=%0d", name, cyc, exp_lat);
      end
   endtask

   task automatic finish_op(input string name);
      repeat (3) begin
         @(negedge clk);
         total++;
         if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_hold got=%b want=1", name, done);
         end
      end
      @(negedge clk);
      trig = 1'b0;
      #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_fall got=%b want=0", name, done);
      end
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle_busy got=%b want=0", name, busy);
      end
   endtask

   task automatic end_counts(input string name, input int exp_writes);
      total++;
      if (writes !== exp_writes) begin
         bad++;
         $display("FAIL %s_writes got=%0d want=%0d", name, writes, exp_writes);
      end
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; trig = 1'b0; row_num = 9'd0; wdata = 512'd0; wmask = 16'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({bram_addr, bram_data, bram_trig, done, busy} !== 48'd0) begin
         bad++;
         $display("FAIL reset_outputs got addr=%h data=%h trig=%b done=%b busy=%b want all 0",
                  bram_addr, bram_data, bram_trig, done, busy);
      end
      rstn = 1'b1;
   endtask

   task automatic test_full_row();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = 32'hA000_0000 + i;
      d_lat = 2; writes = 0;
      start(9'd5, v, 16'hFFFF);
      run_to_done(66, "full");
      end_counts("full", 16);
      finish_op("full");
   endtask

   task automatic test_sparse();
      logic [511:0] v;
      rand_row(v);
      d_lat = 2; writes = 0;
      start(9'd511, v, 16'h8001);
      run_to_done(24, "sparse");
      end_counts("sparse", 2);
      finish_op("sparse");
   endtask

   task automatic test_empty();
      logic [511:0] v;
      rand_row(v);
      d_lat = 2; writes = 0;
      start(9'd100, v, 16'h0000);
      run_to_done(18, "empty");
      end_counts("empty", 0);
      finish_op("empty");
   endtask

   task automatic test_back_to_back();
      logic [511:0] v;
      rand_row(v);
      d_lat = 2; writes = 0;
      start(9'd200, v, 16'h0000);
      run_to_done(18, "b2b_first");
      finish_op("b2b_first");
      rand_row(v);
      start(9'd201, v, 16'h0001);
      run_to_done(21, "b2b_second");
      end_counts("b2b", 1);
      finish_op("b2b_second");
   endtask

   task automatic test_early_drop();
      logic [511:0] v;
      bit done_seen = 1'b0;
      int cyc = 0;
      rand_row(v);
      d_lat = 1; writes = 0;
      start(9'd77, v, 16'hFFFF);
      @(negedge clk);
      scramble();
      repeat (9) @(negedge clk);
      trig = 1'b0;
      while (cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) done_seen = 1'b1;
         if (busy === 1'b0) break;
      end
      total++;
      if (done_seen !== 1'b0) begin
         bad++;
         $display("FAIL drop_done_pulse got=1 want=0");
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL drop_busy got=%b want=0", busy);
      end
      end_counts("drop", 16);
   endtask

   task automatic test_reset_mid_row();
      logic [511:0] v;
      int cyc = 0;
      rand_row(v);
      d_lat = 2; writes = 0;
      start(9'd3, v, 16'hFFFF);
      while (cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (bram_trig === 1'b1 && bram_addr[3:0] == 4'd7) break;
      end
      rstn = 1'b0;
      #1;
      total++;
      if ({bram_trig, done, busy, bram_addr} !== 16'd0) begin
         bad++;
         $display("FAIL midreset_outputs got trig=%b done=%b busy=%b addr=%h want 0",
                  bram_trig, done, busy, bram_addr);
      end
      total++;
      if (writes !== 7) begin
         bad++;
         $display("FAIL midreset_writes got=%0d want=7", writes);
      end
      exp_q.delete();
      trig = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      writes = 0;
      rand_row(v);
      start(9'd3, v, 16'h0003);
      run_to_done(24, "restart");
      end_counts("restart", 2);
      finish_op("restart");
   endtask

   task automatic test_round_trip();
      logic [511:0] v;
      logic [511:0] rd;
      logic [8:0]   row;
      rand_row(v);
      row = 9'($urandom);
      d_lat = 0; writes = 0;
      start(row, v, 16'hFFFF);
      run_to_done(34, "roundtrip");
      end_counts("roundtrip", 16);
      finish_op("roundtrip");
      for (int i = 0; i < 16; i++) rd[511 - 32*i -: 32] = mem[{row, i[3:0]}];
      total++;
      if (rd !== v) begin
         bad++;
         $display("FAIL roundtrip_data got=%h want=%h", rd[511:384], v[511:384]);
      end
   endtask

   initial begin
      test_reset();
      test_full_row();
      test_sparse();
      test_empty();
      test_back_to_back();
      test_early_drop();
      test_reset_mid_row();
      test_round_trip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
